// File: rtl/inst_fetch_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : inst_fetch_sequencer
// Brief    : Multicycle fetch/sequence stage; owns PC, delay-slot NPC and IR.
// Revision : 1.0
// ============================================================================
module inst_fetch_sequencer #(
    parameter logic [31:0] RESET_VECTOR = 32'hBFC00000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        waitrequest,
    input  logic [31:0] readdata,
    input  logic        MemRead,
    input  logic        MemWrite,
    input  logic        jumptrue,
    input  logic        branchtrue,
    input  logic        jrtrue,
    input  logic [31:0] readdata1,
    output logic [31:0] fetch_address,
    output logic        fetch_read,
    output logic        mem_phase,
    output logic [31:0] inst,
    output logic [31:0] pc,
    output logic [31:0] link_addr,
    output logic        end_of_inst_reg,
    output logic        end_of_inst_store,
    output logic        end_j,
    output logic        active
);

    typedef enum logic [1:0] {
        S_FETCH  = 2'd0,
        S_EXEC   = 2'd1,
        S_MEM    = 2'd2,
        S_HALTED = 2'd3
    } state_t;

    localparam logic [31:0] C_INST_STEP = 32'd4;
    localparam logic [31:0] C_LINK_OFS  = 32'd8;

    state_t      r_state_q, w_state_d;
    logic [31:0] r_pc_q, w_pc_d;
    logic [31:0] r_npc_q, w_npc_d;
    logic [31:0] r_inst_q, w_inst_d;
    logic [31:0] r_rs_q, w_rs_d;

    logic        w_complete;
    logic        w_take;
    logic        w_strb_reg;
    logic        w_strb_store;
    logic        w_strb_j;
    logic [31:0] w_pc_plus4;
    logic [31:0] w_br_off;
    logic [31:0] w_jr_target;
    logic [31:0] w_target;

    assign w_pc_plus4  = r_pc_q + C_INST_STEP;
    assign w_br_off    = {{14{r_inst_q[15]}}, r_inst_q[15:0], 2'b00};
    assign w_take      = jrtrue | jumptrue | branchtrue;
    // A jump completing from MEM still uses the rs value captured in EXEC.
    assign w_jr_target = (r_state_q == S_EXEC) ? readdata1 : r_rs_q;

    always_comb begin
        if (jrtrue) begin
            w_target = w_jr_target;
        end else if (jumptrue) begin
            w_target = {w_pc_plus4[31:28], r_inst_q[25:0], 2'b00};
        end else begin
            w_target = w_pc_plus4 + w_br_off;
        end
    end

    always_comb begin
        w_state_d    = r_state_q;
        w_pc_d       = r_pc_q;
        w_npc_d      = r_npc_q;
        w_inst_d     = r_inst_q;
        w_rs_d       = r_rs_q;
        w_complete   = 1'b0;
        w_strb_reg   = 1'b0;
        w_strb_store = 1'b0;
        w_strb_j     = 1'b0;

        case (r_state_q)
            S_FETCH: begin
                if (!waitrequest) begin
                    w_inst_d  = readdata;
                    w_state_d = S_EXEC;
                end
            end
            S_EXEC: begin
                w_rs_d = readdata1;
                if (MemRead | MemWrite) begin
                    w_state_d = S_MEM;
                end else begin
                    w_complete = 1'b1;
                    w_strb_j   = w_take;
                    w_strb_reg = ~w_take;
                end
            end
            S_MEM: begin
                if (!waitrequest) begin
                    w_complete   = 1'b1;
                    w_strb_store = MemWrite;
                    w_strb_reg   = ~MemWrite;
                end
            end
            default: begin
                w_state_d = S_HALTED;
            end
        endcase

        // The delay slot falls out naturally: pc always advances to npc.
        if (w_complete) begin
            w_pc_d    = r_npc_q;
            w_npc_d   = w_take ? w_target : (r_npc_q + C_INST_STEP);
            w_state_d = (r_npc_q == 32'h0) ? S_HALTED : S_FETCH;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state_q <= S_FETCH;
            r_pc_q    <= RESET_VECTOR;
            r_npc_q   <= RESET_VECTOR + C_INST_STEP;
            r_inst_q  <= 32'h0;
            r_rs_q    <= 32'h0;
        end else begin
            r_state_q <= w_state_d;
            r_pc_q    <= w_pc_d;
            r_npc_q   <= w_npc_d;
            r_inst_q  <= w_inst_d;
            r_rs_q    <= w_rs_d;
        end
    end

    assign fetch_address     = r_pc_q;
    assign fetch_read        = (r_state_q == S_FETCH) & ~reset;
    assign mem_phase         = (r_state_q == S_MEM);
    assign inst              = r_inst_q;
    assign pc                = r_pc_q;
    assign link_addr         = r_pc_q + C_LINK_OFS;
    assign end_of_inst_reg   = w_strb_reg;
    assign end_of_inst_store = w_strb_store;
    assign end_j             = w_strb_j;
    assign active            = (r_state_q != S_HALTED);

endmodule
`default_nettype wire
